// File: rtl/bp_predict_ctrl.sv
// bp_predict_ctrl
//   Branch-prediction controller for the fetch stage. A direct-mapped branch
//   target buffer holds a valid bit, tag, target and saturating history
//   counter per entry. Each fetch is looked up and the prediction is
//   registered, so a lookup in cycle N drives the outputs in cycle N+1.
//   Resolved branches from execute train the table. A mispredict starts a
//   one-cycle RECOVER, which steers the PC to the corrected address. A
//   FLUSH window follows, so the front-end stays flushed for FLUSH_CYC
//   cycles in total.
//
//   Optional build macro: BP_PERF_CNT_EN adds the perf_lookups and
//   perf_mispredicts saturating 16-bit event counters.
//
// Handshake: no back-pressure. fetch_pc is sampled on every rising clock
//   edge where fetch_valid = 1. The upd_* inputs are sampled on every
//   rising clock edge where upd_valid = 1. upd_mispredict is ignored unless
//   upd_valid = 1.
//
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   fetch_valid, fetch_pc         fetch lookup request
//   upd_valid, upd_pc, upd_taken,
//   upd_target, upd_mispredict    resolved branch from execute
//   pc_mux_sel                    00 PC+1, 01 predicted, 10 recovery
//   pred_target                   predicted target (valid when sel = 01)
//   recover_target                corrected PC (valid when sel = 10)
//   flush                         front-end flush strobe
//   perf_lookups, perf_mispredicts  event counters (BP_PERF_CNT_EN only)
module bp_predict_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int ENTRIES   = 16,
  parameter int CTR_W     = 2,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  output logic [1:0]        pc_mux_sel,
  output logic [ADDR_W-1:0] pred_target,
  output logic [ADDR_W-1:0] recover_target,
  output logic              flush
`ifdef BP_PERF_CNT_EN
  ,
  output logic [15:0]       perf_lookups,
  output logic [15:0]       perf_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  // Weakly-not-taken: MSB 0 and the remaining bits 1.
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_MAX >> 1;
  // Weakly-taken: MSB 1 and the remaining bits 0.
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);

  localparam logic [1:0] SEL_PC1     = 2'b00;
  localparam logic [1:0] SEL_PRED    = 2'b01;
  localparam logic [1:0] SEL_RECOVER = 2'b10;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RECOVER = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t state;
  logic [FC_W-1:0] flush_cnt;

  // Branch target buffer storage.
  logic [ENTRIES-1:0] tbl_valid;
  logic [TAG_W-1:0]   tbl_tag    [ENTRIES];
  logic [ADDR_W-1:0]  tbl_target [ENTRIES];
  logic [CTR_W-1:0]   tbl_ctr    [ENTRIES];

  logic [IDX_W-1:0]  fetch_idx, upd_idx;
  logic [TAG_W-1:0]  fetch_tag, upd_tag;
  logic              fetch_hit, predict_taken, upd_hit, mispredict;
  logic [ADDR_W-1:0] fix_pc;

  // Table lookups. Both ports read the pre-update contents, so a same-cycle
  // update to the fetched index is not bypassed into the prediction.
  // A stored target of 0 means "no branch", so it never counts as a hit.
  always_comb begin
    fetch_idx     = fetch_pc[IDX_W-1:0];
    fetch_tag     = fetch_pc[ADDR_W-1:IDX_W];
    upd_idx       = upd_pc[IDX_W-1:0];
    upd_tag       = upd_pc[ADDR_W-1:IDX_W];
    fetch_hit     = tbl_valid[fetch_idx] && (tbl_tag[fetch_idx] == fetch_tag) &&
                    (tbl_target[fetch_idx] != '0);
    predict_taken = fetch_hit && tbl_ctr[fetch_idx][CTR_W-1];
    upd_hit       = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag) &&
                    (tbl_target[upd_idx] != '0);
    mispredict    = upd_valid && upd_mispredict;
    // The not-taken fall-through address wraps at the top of memory.
    fix_pc        = upd_taken ? upd_target : (upd_pc + ADDR_W'(1));
  end

  // Table training. This runs on every resolved branch, whatever the FSM
  // state is.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tbl_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_ctr[i]    <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (tbl_ctr[upd_idx] != CTR_MAX) tbl_ctr[upd_idx] <= tbl_ctr[upd_idx] + CTR_W'(1);
          tbl_target[upd_idx] <= upd_target;
        end else if (tbl_ctr[upd_idx] != '0) begin
          tbl_ctr[upd_idx] <= tbl_ctr[upd_idx] - CTR_W'(1);
        end
      end else if (upd_taken && (upd_target != '0)) begin
        tbl_valid[upd_idx]  <= 1'b1;
        tbl_tag[upd_idx]    <= upd_tag;
        tbl_target[upd_idx] <= upd_target;
        tbl_ctr[upd_idx]    <= CTR_WT;
      end
    end
  end

  // Control FSM with registered outputs. A mispredict has priority in every
  // state, so the newest mispredict always restarts RECOVER with its own
  // corrected PC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      flush_cnt      <= '0;
      pc_mux_sel     <= SEL_PC1;
      pred_target    <= '0;
      recover_target <= '0;
      flush          <= 1'b0;
    end else if (mispredict) begin
      state          <= RECOVER;
      pc_mux_sel     <= SEL_RECOVER;
      pred_target    <= '0;
      recover_target <= fix_pc;
      flush          <= 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          flush          <= 1'b0;
          recover_target <= '0;
          if (fetch_valid && predict_taken) begin
            pc_mux_sel  <= SEL_PRED;
            pred_target <= tbl_target[fetch_idx];
          end else begin
            pc_mux_sel  <= SEL_PC1;
            pred_target <= '0;
          end
        end
        RECOVER: begin
          pc_mux_sel     <= SEL_PC1;
          pred_target    <= '0;
          recover_target <= '0;
          flush_cnt      <= FC_W'(FLUSH_CYC - 1);
          if (FLUSH_CYC > 1) begin
            state <= FLUSH;
            flush <= 1'b1;
          end else begin
            state <= RUN;
            flush <= 1'b0;
          end
        end
        FLUSH: begin
          // Predictions are suppressed for the whole window.
          pc_mux_sel     <= SEL_PC1;
          pred_target    <= '0;
          recover_target <= '0;
          flush_cnt      <= flush_cnt - FC_W'(1);
          if (flush_cnt <= FC_W'(1)) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            flush <= 1'b1;
          end
        end
        default: begin
          state          <= RUN;
          pc_mux_sel     <= SEL_PC1;
          pred_target    <= '0;
          recover_target <= '0;
          flush          <= 1'b0;
        end
      endcase
    end
  end

`ifdef BP_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_lookups     <= '0;
      perf_mispredicts <= '0;
    end else begin
      if ((state == RUN) && fetch_valid && (perf_lookups != 16'hFFFF))
        perf_lookups <= perf_lookups + 16'd1;
      if (mispredict && (perf_mispredicts != 16'hFFFF))
        perf_mispredicts <= perf_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_predict_ctrl.sv
// tb_bp_predict_ctrl
//   Directed bench for bp_predict_ctrl (defaults: ADDR_W 16, ENTRIES 16,
//   CTR_W 2, FLUSH_CYC 2). The driver applies one input vector per clock and
//   pushes the hand-computed outputs expected after that edge. The monitor
//   pops entries on the falling edge and compares them with the DUT outputs.
module tb_bp_predict_ctrl;

  logic        clock, reset;
  logic        fetch_valid;
  logic [15:0] fetch_pc;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_mispredict;
  logic [1:0]  pc_mux_sel;
  logic [15:0] pred_target;
  logic [15:0] recover_target;
  logic        flush;

  bp_predict_ctrl #(
    .ADDR_W(16), .ENTRIES(16), .CTR_W(2), .FLUSH_CYC(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_mispredict(upd_mispredict),
    .pc_mux_sel(pc_mux_sel),
    .pred_target(pred_target),
    .recover_target(recover_target),
    .flush(flush)
  );

  // Clock and reset block.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  id;
    logic [1:0]  sel;
    logic [15:0] pt;
    logic [15:0] rt;
    logic        fl;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   vid    = 0;

  // Driver: apply one vector for one clock, then queue the expected outputs.
  task automatic vec(input logic fv, input logic [15:0] fpc,
                     input logic uv, input logic [15:0] upc, input logic ut,
                     input logic [15:0] utgt, input logic um,
                     input logic [1:0] es, input logic [15:0] ept,
                     input logic [15:0] ert, input logic efl);
    exp_t e;
    fetch_valid    = fv;
    fetch_pc       = fpc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utgt;
    upd_mispredict = um;
    @(posedge clock);
    #1;
    e.id  = 8'(vid);
    e.sel = es;
    e.pt  = ept;
    e.rt  = ert;
    e.fl  = efl;
    exp_q.push_back(e);
    vid++;
  endtask

  task automatic idle_inputs();
    fetch_valid    = 1'b0;
    fetch_pc       = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_mispredict = 1'b0;
  endtask

  // Asynchronous reset check: all outputs must already be zero, between edges.
  task automatic check_reset_outputs(input string name);
    n_vec++;
    if (pc_mux_sel !== 2'b00 || flush !== 1'b0 || pred_target !== 16'h0 ||
        recover_target !== 16'h0) begin
      n_miss++;
      $display("FAIL %s: sel=%b flush=%b pt=%h rt=%h, required all zero",
               name, pc_mux_sel, flush, pred_target, recover_target);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic bad;
      e   = exp_q.pop_front();
      bad = 1'b0;
      n_vec++;
      if (pc_mux_sel !== e.sel) begin
        bad = 1'b1;
        $display("FAIL v%0d pc_mux_sel: got %b, required %b", e.id, pc_mux_sel, e.sel);
      end
      if (flush !== e.fl) begin
        bad = 1'b1;
        $display("FAIL v%0d flush: got %b, required %b", e.id, flush, e.fl);
      end
      if (e.sel == 2'b01 && pred_target !== e.pt) begin
        bad = 1'b1;
        $display("FAIL v%0d pred_target: got %h, required %h", e.id, pred_target, e.pt);
      end
      if (e.sel == 2'b10 && recover_target !== e.rt) begin
        bad = 1'b1;
        $display("FAIL v%0d recover_target: got %h, required %h", e.id, recover_target, e.rt);
      end
      if (bad) n_miss++;
    end
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    #3 reset = 1'b1;
    #1 check_reset_outputs("reset_async");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Columns: fv fpc | uv upc ut utgt um | sel pt rt flush
    vec(1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v0 cold miss
    vec(0, 16'h0000, 1, 16'h0043, 1, 16'h0100, 0, 2'b00, 16'h0, 16'h0, 0); // v1 allocate
    vec(1, 16'h0043, 0, 16'h0000, 0, 16'h0000, 0, 2'b01, 16'h0100, 16'h0, 0); // v2 predict
    vec(1, 16'h0043, 1, 16'h0043, 0, 16'h0000, 0, 2'b01, 16'h0100, 16'h0, 0); // v3 pre-update, ctr 10->01
    vec(1, 16'h0043, 1, 16'h0043, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v4 ctr 01->00
    vec(1, 16'h0043, 1, 16'h0043, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v5 ctr 00->00
    vec(1, 16'h0043, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v6
    vec(1, 16'h0043, 1, 16'h0043, 1, 16'h0100, 0, 2'b00, 16'h0, 16'h0, 0); // v7 sees 00, ->01
    vec(1, 16'h0043, 1, 16'h0043, 1, 16'h0100, 0, 2'b00, 16'h0, 16'h0, 0); // v8 sees 01, ->10
    vec(1, 16'h0043, 0, 16'h0000, 0, 16'h0000, 0, 2'b01, 16'h0100, 16'h0, 0); // v9 sees 10
    vec(0, 16'h0000, 1, 16'h0043, 1, 16'h0100, 0, 2'b00, 16'h0, 16'h0, 0); // v10 ->11
    vec(0, 16'h0000, 1, 16'h0043, 1, 16'h0100, 0, 2'b00, 16'h0, 16'h0, 0); // v11 11 stays
    vec(0, 16'h0000, 1, 16'h0043, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v12 ->10
    vec(1, 16'h0043, 0, 16'h0000, 0, 16'h0000, 0, 2'b01, 16'h0100, 16'h0, 0); // v13 still taken
    vec(0, 16'h0043, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v14 fetch_valid 0

    // Recovery with wrap at the top of memory.
    vec(1, 16'h0043, 1, 16'hFFFF, 0, 16'h1234, 1, 2'b10, 16'h0, 16'h0000, 1); // v15 RECOVER
    vec(1, 16'h0043, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 1); // v16 FLUSH, suppressed
    vec(1, 16'h0043, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v17 window ends
    vec(1, 16'h0043, 0, 16'h0000, 0, 16'h0000, 0, 2'b01, 16'h0100, 16'h0, 0); // v18 RUN again

    // Back-to-back: a mispredict during FLUSH, then a mispredict during RECOVER.
    vec(0, 16'h0000, 1, 16'h0050, 0, 16'h0000, 1, 2'b10, 16'h0, 16'h0051, 1); // v19
    vec(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 1); // v20 FLUSH
    vec(0, 16'h0000, 1, 16'h0060, 1, 16'h0200, 1, 2'b10, 16'h0, 16'h0200, 1); // v21 re-RECOVER
    vec(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 1); // v22 window restarts
    vec(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v23
    vec(0, 16'h0000, 1, 16'h0070, 0, 16'h0000, 1, 2'b10, 16'h0, 16'h0071, 1); // v24
    vec(0, 16'h0000, 1, 16'h0080, 1, 16'h0300, 1, 2'b10, 16'h0, 16'h0300, 1); // v25 newest wins
    vec(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 1); // v26 FLUSH

    // Reset in the middle of FLUSH.
    idle_inputs();
    @(negedge clock);
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset_mid_flush");
    @(negedge clock);
    reset = 1'b0;

    // The table was cleared, then the tag alias cases run.
    vec(1, 16'h0043, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v27 cleared
    vec(0, 16'h0000, 1, 16'h0013, 1, 16'h0100, 0, 2'b00, 16'h0, 16'h0, 0); // v28 allocate
    vec(1, 16'h0013, 0, 16'h0000, 0, 16'h0000, 0, 2'b01, 16'h0100, 16'h0, 0); // v29
    vec(1, 16'h0023, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v30 tag mismatch
    vec(1, 16'h0013, 1, 16'h0023, 1, 16'h0000, 0, 2'b01, 16'h0100, 16'h0, 0); // v31 target 0
    vec(1, 16'h0023, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v32
    vec(1, 16'h0013, 0, 16'h0000, 0, 16'h0000, 0, 2'b01, 16'h0100, 16'h0, 0); // v33 entry kept
    vec(0, 16'h0000, 1, 16'h0013, 1, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v34 hit, target->0
    vec(1, 16'h0013, 0, 16'h0000, 0, 16'h0000, 0, 2'b00, 16'h0, 16'h0, 0); // v35 no predict

    idle_inputs();
    repeat (3) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bp_predict_ctrl.md
Name: bp_predict_ctrl

Overview:
Parametrised branch-prediction controller for the fetch stage. It replaces the single-bit predictor/mux-select pairing with a direct-mapped branch target buffer, saturating history counters and mispredict recovery. It generates a registered PC mux select, the predicted target, and a flush window for the front-end stages. The execute stage updates it with resolved branches.

Parameters:
ADDR_W, 16, PC/target width in bits (word-addressed PC)
ENTRIES, 16, BTB/BHT entries; power of 2, minimum 2; IDX_W = clog2(ENTRIES)
CTR_W, 2, history counter width; minimum 1
FLUSH_CYC, 2, cycles flush is held after a mispredict; minimum 1

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
fetch_valid  input  1  fetch_pc is valid this cycle
fetch_pc  input  ADDR_W  PC being fetched
upd_valid  input  1  resolved branch from execute
upd_pc  input  ADDR_W  PC of resolved branch
upd_taken  input  1  actual branch outcome
upd_target  input  ADDR_W  actual branch target address
upd_mispredict  input  1  execute detected a wrong prediction; qualified by upd_valid
pc_mux_sel  output  2  00 = PC+1, 01 = predicted target, 10 = recovery target
pred_target  output  ADDR_W  predicted target; valid when pc_mux_sel = 01
recover_target  output  ADDR_W  corrected PC; valid when pc_mux_sel = 10
flush  output  1  front-end flush strobe

Behaviour:
- Reset (asynchronous): all outputs 0; all entry valid bits 0; all counters set to weakly-not-taken (MSB 0, remaining bits 1; for CTR_W = 2 this is 01); FSM enters RUN.
- Entry contents: valid bit, tag = pc[ADDR_W-1:IDX_W], target, counter. Index = pc[IDX_W-1:0].
- All outputs are registered: a lookup at cycle N drives outputs in cycle N+1.
- Hit: entry valid, tag matches, and stored target != 0.
- Predict taken: hit and counter MSB = 1. A target of 0 is the "no branch" encoding and never predicts taken.
- FSM states:
  - RUN: if upd_valid && upd_mispredict, go to RECOVER. Otherwise, when fetch_valid and predict taken, drive pc_mux_sel = 01 and pred_target = entry target; else pc_mux_sel = 00.
  - RECOVER: lasts exactly one cycle.
    - pc_mux_sel = 10, flush = 1.
    - recover_target = upd_target if upd_taken, else upd_pc + 1 (modulo 2^ADDR_W; wraps at the top of memory).
    - Load a down-counter with FLUSH_CYC-1. Go to FLUSH if FLUSH_CYC > 1, else RUN.
  - FLUSH: flush = 1, pc_mux_sel = 00, predictions suppressed; decrement the counter; return to RUN when it reaches 0.
- A mispredict arriving in RECOVER or FLUSH restarts RECOVER with the new recovery target. The newest mispredict wins.
- Table update (every upd_valid, independent of FSM state):
  - On hit: counter saturating-increments if taken, saturating-decrements if not; target is overwritten if taken.
  - On miss with upd_taken and upd_target != 0: allocate the entry (overwrite), set tag and target, counter = weakly-taken (MSB 1, rest 0).
  - On miss with not-taken: no change.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents (no bypass).
- fetch_valid = 0 in RUN: pc_mux_sel = 00. The table is still updated.
- Reset mid-RECOVER or mid-FLUSH: abort immediately; outputs return to 0.

Optional Feature:
BP_PERF_CNT_EN:
- When defined, adds two outputs: perf_lookups (16 bits) and perf_mispredicts (16 bits).
  - perf_lookups counts RUN-state cycles with fetch_valid = 1.
  - perf_mispredicts counts upd_valid && upd_mispredict.
  - Both saturate at 0xFFFF and reset to 0.
- When undefined, these ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Reset: assert reset mid-clock, then release. Required: pc_mux_sel = 00, flush = 0, all outputs 0 asynchronously. A fetch of 0x0040 gives pc_mux_sel = 00 (miss).
- Allocation: upd_valid, upd_pc = 0x0043, upd_taken = 1, upd_target = 0x0100. Then fetch 0x0043. Required: the next cycle has pc_mux_sel = 01 and pred_target = 0x0100.
- Saturation: three not-taken updates at 0x0043. Required: the counter goes 10 -> 01 -> 00 -> 00, and a fetch of 0x0043 gives pc_mux_sel = 00.
- Recovery: FLUSH_CYC = 2, mispredict with upd_pc = 0xFFFF, not-taken. Required:
  - Cycle 1: pc_mux_sel = 10, recover_target = 0x0000 (wrap), flush = 1.
  - Cycle 2: flush = 1, pc_mux_sel = 00.
  - Cycle 3: flush = 0.
- Back-to-back: a second mispredict (taken, target 0x0200) during FLUSH. Required: RECOVER re-enters with recover_target = 0x0200 and the flush window restarts.
- Tag alias: ENTRIES = 16; an entry is allocated for 0x0013 (target 0x0100), then 0x0023 is fetched. Required: pc_mux_sel = 00 (tag mismatch). A target-0 update for 0x0023 does not allocate.
